mux_scan_ctrl: RTL

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/mux_scan_ctrl.sv
// Scans a downstream 4:1 mux channel by channel, waiting SETTLE cycles after each
// select change before capturing mux_out, and publishes the four bits as one word.
//
// state | meaning
// IDLE  | waiting for start, select parked at 00
// SCAN  | stepping ch 0..3, settling then capturing mux_out per channel
// DONE  | one-cycle done pulse, sample holds the completed scan
module mux_scan_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       mux_out,
  output logic       sel1,
  output logic       sel2,
  output logic       busy,
  output logic       done,
  output logic [3:0] sample
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t     state, state_nxt;
  logic [1:0] ch, ch_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [3:0] shadow, shadow_nxt;
  logic [3:0] sample_nxt;
  logic [1:0] sel_nxt;
  logic       busy_nxt, done_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ch     <= 2'd0;
      cnt    <= 4'd0;
      shadow <= 4'd0;
      sample <= 4'd0;
      sel1   <= 1'b0;
      sel2   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      ch     <= ch_nxt;
      cnt    <= cnt_nxt;
      shadow <= shadow_nxt;
      sample <= sample_nxt;
      sel1   <= sel_nxt[1];
      sel2   <= sel_nxt[0];
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ch_nxt     = ch;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    sample_nxt = sample;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = SCAN;
          ch_nxt    = 2'd0;
          cnt_nxt   = 4'd0;
        end
      end
      SCAN: begin
        if (abort) begin
          state_nxt = IDLE;
          ch_nxt    = 2'd0;
          cnt_nxt   = 4'd0;
        end else if (cnt < SETTLE_C) begin
          cnt_nxt = cnt + 4'd1;
        end else begin
          shadow_nxt[ch] = mux_out;
          cnt_nxt        = 4'd0;
          if (ch == 2'd3) begin
            // publish including the bit captured on this very edge
            state_nxt  = DONE;
            sample_nxt = shadow_nxt;
            ch_nxt     = 2'd0;
          end else begin
            ch_nxt = ch + 2'd1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        ch_nxt    = 2'd0;
        cnt_nxt   = 4'd0;
      end
      default: begin
        state_nxt = IDLE;
        ch_nxt    = 2'd0;
        cnt_nxt   = 4'd0;
      end
    endcase

    // outputs are registered from the next-state view so they line up with state
    sel_nxt  = (state_nxt == SCAN) ? ch_nxt : 2'b00;
    busy_nxt = (state_nxt == SCAN);
    done_nxt = (state_nxt == DONE);
  end

endmodule
